// File: rtl/instb_pkg.sv
// Shared defaults and FSM state encoding for the instruction-buffer fetch unit.
package instb_pkg;

    localparam int INSTB_AW = 12;
    localparam int INSTB_DW = 128;
    localparam int INSTB_FD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/instb_fetch_fifo.sv
// Synchronous prefetch FIFO with occupancy count; flush empties it in one cycle.
module instb_fetch_fifo
    import instb_pkg::*;
#(
    parameter int W     = INSTB_DW + INSTB_AW,
    parameter int DEPTH = INSTB_FD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and count bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instb_fetch.sv
// Instruction fetch: streams lines from the instruction buffer into a
// prefetch FIFO and hands them to the decoder in address order.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing buffer reads while lines remain and FIFO has room
//   ST_DRAIN | all reads issued; waiting for FIFO and in-flight read to empty
module instb_fetch
    import instb_pkg::*;
#(
    parameter int AW = INSTB_AW,
    parameter int DW = INSTB_DW,
    parameter int FD = INSTB_FD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   start_num,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    input  logic [AW:0]   redirect_num,
    output logic          busy,
    output logic          done,
    output logic          instb_enb,
    output logic [AW-1:0] instb_addrb,
    input  logic [DW-1:0] instb_doutb,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_addr
);

    localparam int CW = $clog2(FD) + 1;
    localparam logic [CW:0] FD_LIM = (CW + 1)'(FD);

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW:0]     rem;
    logic            inflight;
    logic [AW-1:0]   inflight_addr;

    logic            issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occ;
    logic [DW+AW-1:0] fifo_head;

    // Issue decision: occupancy counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        occ   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
        issue = (state == ST_FETCH) && (rem != '0) && (occ < FD_LIM) && !redirect && !rst;
        flush = redirect && (state != ST_IDLE);
        push  = inflight && !redirect;
        pop   = inst_valid && inst_ready;
    end

    instb_fetch_fifo #(
        .W     (DW + AW),
        .DEPTH (FD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({instb_doutb, inflight_addr}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Fetch FSM with pc/rem bookkeeping and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= '0;
            rem           <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            done          <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) inflight_addr <= pc;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= start_addr;
                        rem   <= start_num;
                        state <= (start_num == '0) ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        pc    <= redirect_addr;
                        rem   <= redirect_num;
                        state <= (redirect_num == '0) ? ST_DRAIN : ST_FETCH;
                    end else if (issue) begin
                        pc  <= pc + 1'b1;
                        rem <= rem - 1'b1;
                        if (rem == (AW + 1)'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        pc    <= redirect_addr;
                        rem   <= redirect_num;
                        state <= (redirect_num == '0) ? ST_DRAIN : ST_FETCH;
                    end else if (fifo_empty && !inflight) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign instb_enb   = issue;
    assign instb_addrb = pc;
    assign inst_valid  = !fifo_empty;
    assign inst_data   = inst_valid ? fifo_head[AW +: DW] : '0;
    assign inst_addr   = inst_valid ? fifo_head[AW-1:0]   : '0;

endmodule

// File: tb/tb_instb_fetch.sv
// Self-checking bench for instb_fetch: a behavioural instruction buffer,
// an address-order scoreboard, a vector table of fetch runs and a few
// hand-written sequences for redirect, reset and zero-length corners.
module tb_instb_fetch;

    localparam int AW = 12;
    localparam int DW = 128;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   start_num;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [AW:0]   redirect_num;
    logic          busy;
    logic          done;
    logic          instb_enb;
    logic [AW-1:0] instb_addrb;
    logic [DW-1:0] instb_doutb = '0;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_addr;

    instb_fetch #(.AW(AW), .DW(DW), .FD(FD)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .start_num     (start_num),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .redirect_num  (redirect_num),
        .busy          (busy),
        .done          (done),
        .instb_enb     (instb_enb),
        .instb_addrb   (instb_addrb),
        .instb_doutb   (instb_doutb),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_addr     (inst_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {20'hC0DE0, a, ~{20'h0, a}, {a, a, 8'h5A}, {20'hABCDE, a}};
    endfunction

    // Instruction buffer: registered read, one cycle latency.
    always @(posedge clk) begin
        if (instb_enb) instb_doutb <= data_of(instb_addrb);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_count = 0;
    int done_count = 0;
    int n_deliv  = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    logic [AW-1:0] exp_q[$];

    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: counts reads and done pulses, checks hold-under-stall and
    // compares every delivered line against the scoreboard head.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        if (instb_enb) rd_count++;
        if (done) done_count++;
        if (!rst && inst_valid && prev_stall) begin
            chk_eq("hold_addr", inst_addr, prev_addr);
            chk_eq("hold_data", inst_data, prev_data);
        end
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_line", inst_addr, 0);
            end else begin
                ea = exp_q.pop_front();
                chk_eq("line_addr", inst_addr, ea);
                chk_eq("line_data", inst_data, data_of(ea));
            end
            if (n_deliv == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_deliv++;
        end
        prev_stall = !rst && inst_valid && !inst_ready;
        prev_addr  = inst_addr;
        prev_data  = inst_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lines(input logic [AW-1:0] addr, input logic [AW:0] num);
        logic [AW-1:0] a;
        a = addr;
        for (int i = 0; i < int'(num); i++) begin
            exp_q.push_back(a);
            a = a + 1'b1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] addr, input logic [AW:0] num);
        expect_lines(addr, num);
        start      = 1'b1;
        start_addr = addr;
        start_num  = num;
        step();
        start = 1'b0;
    endtask

    task automatic clear_run();
        rd_count   = 0;
        done_count = 0;
        n_deliv    = 0;
        exp_q.delete();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_count == 0 && n < 400) begin
            step();
            n++;
        end
        repeat (3) step();
        chk_eq({name, "_done_once"}, done_count, 1);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   num;
        int            stall;
        int            stall_reads;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{12'h010, 13'd8,  0,  0};
        vecs[1] = '{12'h100, 13'd16, 20, 4};
        vecs[2] = '{12'hFFE, 13'd4,  0,  0};
        vecs[3] = '{12'h3F0, 13'd0,  0,  0};
        vecs[4] = '{12'h7FF, 13'd5,  3,  3};

        rst = 1'b1; start = 1'b0; start_addr = '0; start_num = '0;
        redirect = 1'b0; redirect_addr = '0; redirect_num = '0; inst_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk_eq("rst_busy",   busy, 0);
        chk_eq("rst_done",   done, 0);
        chk_eq("rst_enb",    instb_enb, 0);
        chk_eq("rst_valid",  inst_valid, 0);
        chk_eq("rst_addrb",  instb_addrb, 0);
        chk_eq("rst_iaddr",  inst_addr, 0);
        chk_eq("rst_idata",  inst_data, 0);
        step();
        rst = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            clear_run();
            inst_ready = (vecs[v].stall == 0);
            do_start(vecs[v].addr, vecs[v].num);
            if (vecs[v].stall > 0) begin
                start = 1'b1; start_addr = 12'h555; start_num = 13'd3;
                step();
                start = 1'b0;
                repeat (vecs[v].stall - 1) step();
                chk_eq("stall_reads", rd_count, vecs[v].stall_reads);
                inst_ready = 1'b1;
            end
            wait_done("vec");
            chk_eq("vec_reads",   rd_count, int'(vecs[v].num));
            chk_eq("vec_deliv",   n_deliv,  int'(vecs[v].num));
            chk_eq("vec_q_empty", exp_q.size(), 0);
            chk_eq("vec_idle",    busy, 0);
            if (vecs[v].stall == 0 && vecs[v].num != '0)
                chk_eq("vec_span", last_cyc - first_cyc, int'(vecs[v].num) - 1);
        end

        // Redirect with three lines buffered and one read in flight.
        clear_run();
        inst_ready = 1'b0;
        do_start(12'h040, 13'd20);
        begin
            int n;
            n = 0;
            while (rd_count < 4 && n < 50) begin
                step();
                n++;
            end
        end
        chk_eq("redir_setup_reads", rd_count, 4);
        chk_eq("redir_setup_valid", inst_valid, 1);
        redirect = 1'b1; redirect_addr = 12'h200; redirect_num = 13'd2; inst_ready = 1'b1;
        @(negedge clk);
        chk_eq("redir_no_issue", instb_enb, 0);
        step();
        redirect = 1'b0;
        exp_q.delete();
        expect_lines(12'h200, 13'd2);
        chk_eq("redir_handshake", n_deliv, 1);
        wait_done("redir");
        chk_eq("redir_reads", rd_count, 6);
        chk_eq("redir_deliv", n_deliv, 3);
        chk_eq("redir_q_empty", exp_q.size(), 0);

        // Redirect alone in IDLE is ignored.
        clear_run();
        redirect = 1'b1; redirect_addr = 12'h600; redirect_num = 13'd3;
        step();
        redirect = 1'b0;
        repeat (4) step();
        chk_eq("idle_redir_busy",  busy, 0);
        chk_eq("idle_redir_reads", rd_count, 0);

        // Start and redirect together in IDLE: start wins.
        clear_run();
        redirect = 1'b1; redirect_addr = 12'h600; redirect_num = 13'd3;
        do_start(12'h300, 13'd2);
        redirect = 1'b0;
        wait_done("both");
        chk_eq("both_reads", rd_count, 2);
        chk_eq("both_deliv", n_deliv, 2);

        // Zero-length run: DRAIN for one cycle then done, no reads.
        clear_run();
        do_start(12'h3F0, 13'd0);
        @(negedge clk);
        chk_eq("zero_busy", busy, 1);
        chk_eq("zero_done_early", done, 0);
        @(negedge clk);
        chk_eq("zero_done", done, 1);
        @(negedge clk);
        chk_eq("zero_done_clear", done, 0);
        chk_eq("zero_idle", busy, 0);
        chk_eq("zero_reads", rd_count, 0);

        // Reset in the middle of FETCH.
        clear_run();
        inst_ready = 1'b0;
        do_start(12'h080, 13'd10);
        step();
        step();
        rst = 1'b1;
        start = 1'b1; start_addr = 12'h111; start_num = 13'd2;
        @(negedge clk);
        chk_eq("mid_rst_enb", instb_enb, 0);
        step();
        start = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_busy",  busy, 0);
        chk_eq("mid_rst_done",  done, 0);
        chk_eq("mid_rst_valid", inst_valid, 0);
        chk_eq("mid_rst_addrb", instb_addrb, 0);
        chk_eq("mid_rst_iaddr", inst_addr, 0);
        chk_eq("mid_rst_idata", inst_data, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_eq("post_rst_valid", inst_valid, 0);
        step();
        @(negedge clk);
        chk_eq("post_rst_valid2", inst_valid, 0);
        chk_eq("post_rst_busy",   busy, 0);

        // Normal run after reset still works.
        clear_run();
        inst_ready = 1'b1;
        do_start(12'h0A0, 13'd3);
        wait_done("after_rst");
        chk_eq("after_rst_deliv", n_deliv, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instb_fetch.md
INSTB_FETCH -- requirements
Module: instb_fetch

Interface
REQ-001 Parameter AW, default 12: instruction-buffer address width in 128-bit lines.
REQ-002 Parameter DW, default 128: instruction line width.
REQ-003 Parameter FD, default 4: prefetch FIFO depth, power of two, at least 2.
REQ-004 clk  in  1  sole clock.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that begins a fetch run.
REQ-007 start_addr  in  AW  first line address of the run.
REQ-008 start_num  in  AW+1  number of lines to fetch (0..2^AW).
REQ-009 redirect  in  1  one-cycle pulse that flushes and restarts the fetch.
REQ-010 redirect_addr  in  AW  new line address after a redirect.
REQ-011 redirect_num  in  AW+1  new remaining line count after a redirect.
REQ-012 busy  out  1  high while the state is not IDLE.
REQ-013 done  out  1  one-cycle pulse when a run completes.
REQ-014 instb_enb  out  1  buffer read enable (read port).
REQ-015 instb_addrb  out  AW  buffer read address.
REQ-016 instb_doutb  in  DW  buffer read data, valid exactly one cycle after instb_enb.
REQ-017 inst_valid  out  1  instruction line available to the decoder.
REQ-018 inst_ready  in  1  decoder accepts the line.
REQ-019 inst_data  out  DW  instruction line.
REQ-020 inst_addr  out  AW  line address of inst_data.

Function
REQ-021 The state machine SHALL have three states: IDLE, FETCH and DRAIN.
REQ-022 In IDLE, start SHALL load pc=start_addr and rem=start_num and go to FETCH; if start_num==0 it SHALL go to DRAIN instead.
REQ-023 In FETCH, the block SHALL assert instb_enb with instb_addrb=pc only when rem>0 and fifo_count+inflight<FD, then increment pc modulo 2^AW and decrement rem.
REQ-024 The block SHALL issue at most one read per cycle, which gives one line per cycle of sustained throughput when inst_ready is held high.
REQ-025 When rem reaches 0, FETCH SHALL transition to DRAIN.
REQ-026 DRAIN SHALL exit to IDLE, pulsing done for one cycle, on the first cycle in which the FIFO is empty and no read is in flight.
REQ-027 Read data SHALL be pushed into the FIFO together with its address on the cycle after instb_enb; the FIFO SHALL never overflow by construction.
REQ-028 inst_valid SHALL equal FIFO not-empty, and inst_data/inst_addr SHALL be the FIFO head; a pop SHALL occur on inst_valid&inst_ready.
REQ-029 inst_data and inst_addr SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-031 A redirect in FETCH or DRAIN SHALL empty the FIFO, discard any in-flight read return, load pc=redirect_addr and rem=redirect_num, and go to FETCH (DRAIN if redirect_num==0).
REQ-032 A handshake in the same cycle as a redirect SHALL count as delivered.
REQ-033 No read SHALL be issued in the redirect cycle.
REQ-034 redirect SHALL be ignored in IDLE; start SHALL be ignored unless the state is IDLE.
REQ-035 If start and redirect are asserted together in IDLE, start SHALL be taken.
REQ-036 Lines SHALL be delivered strictly in address order (with wrap-around) between redirects.

Reset
REQ-037 On rst the block SHALL enter IDLE and clear pc, rem, the FIFO pointers and count, and the in-flight flag.
REQ-038 On rst, busy, done, instb_enb, inst_valid, instb_addrb, inst_addr and inst_data SHALL all be 0.
REQ-039 A read return arriving on the cycle after rst SHALL be discarded.
REQ-040 rst SHALL override start and redirect.

Structure
REQ-041 Package instb_pkg SHALL hold AW, DW, FD defaults and the state encoding constants.
REQ-042 The FIFO SHALL be a sub-module instb_fetch_fifo (synchronous, width DW+AW, depth FD, with count output); the fetch control logic stays in instb_fetch.

Verification
REQ-043 Stream: start_addr=0x010, start_num=8, inst_ready=1 -> addresses 0x010..0x017 delivered on 8 consecutive cycles; done pulses once; no extra instb_enb.
REQ-044 Backpressure: start_num=16, inst_ready=0 for 20 cycles, then 1 -> at most FD reads issued before release; all 16 lines delivered in order; no loss or duplication.
REQ-045 Wrap: start_addr=0xFFE, start_num=4 -> lines 0xFFE, 0xFFF, 0x000, 0x001 delivered.
REQ-046 Redirect: redirect at 0x200 with redirect_num=2, asserted mid-run with FIFO holding 3 lines and one read in flight -> no stale line appears after the redirect cycle; next lines are 0x200 and 0x201; then done.
REQ-047 Corners: start_num=0 -> done pulses after the DRAIN cycle with zero reads; rst asserted mid-FETCH -> all outputs 0 next cycle and the late read return is discarded.
